audio_adc_rx: RTL and testbench

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_adc_rx_sync_edge.sv | 48 ++++
 rtl/audio_adc_rx.sv | 166 ++++++++++++++++
 tb/tb_audio_adc_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S ADC receive path.
package audio_pkg;

  localparam int unsigned SAMPLE_W       = 24;
  localparam int unsigned I2S_DELAY_BITS = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SHIFT,
    ST_WAIT
  } rx_state_e;

endpackage

// File: rtl/audio_adc_rx_sync_edge.sv
// Multi-flop synchronizer for codec pins with optional rise/fall detection.
module sync_edge #(
  parameter int unsigned W        = 1,
  parameter int unsigned STAGES   = 2,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

  if (EDGE_DET) begin : g_edge
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= '0;
      else        prev_q <= q;
    end

    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
  end else begin : g_no_edge
    assign rise = '0;
    assign fall = '0;
  end

endmodule

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: deserializes left/right words into a valid/ready pair stream.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    bclk,
  input  logic                    adclrc,
  input  logic                    adcdat,
  output logic signed [WIDTH-1:0] data_left,
  output logic signed [WIDTH-1:0] data_right,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic                    clr_flags
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH + I2S_DELAY_BITS + 1);
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(I2S_DELAY_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH + I2S_DELAY_BITS - 1);

  logic       bclk_lvl_unused, bclk_fall_unused, bit_ev;
  logic [1:0] pins_s, pins_rise_unused, pins_fall_unused;
  logic       lrc_s, dat_s;

  sync_edge #(.W(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_bclk_sync (
    .clk(sys_clk), .rst_n(reset), .d(bclk),
    .q(bclk_lvl_unused), .rise(bit_ev), .fall(bclk_fall_unused)
  );

  sync_edge #(.W(2), .STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_pin_sync (
    .clk(sys_clk), .rst_n(reset), .d({adclrc, adcdat}),
    .q(pins_s), .rise(pins_rise_unused), .fall(pins_fall_unused)
  );

  assign lrc_s = pins_s[1];
  assign dat_s = pins_s[0];

  rx_state_e               state_q, state_d;
  logic                    lrc_prev_q, lrc_prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        shift_q, shift_d, left_hold_q, left_hold_d, word;
  logic                    left_ok_q, left_ok_d;
  logic signed [WIDTH-1:0] data_left_q, data_left_d, data_right_q, data_right_d;
  logic                    out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;
  logic                    lr_chg, pair_done, err_ev;

  assign lr_chg = (lrc_s != lrc_prev_q);
  assign word   = {shift_q[WIDTH-2:0], dat_s};

  always_comb begin
    state_d     = state_q;
    lrc_prev_d  = lrc_prev_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    pair_done   = 1'b0;
    err_ev      = 1'b0;

    // cnt counts bit events since the LR change, the discarded delay bit included
    if (bit_ev) begin
      lrc_prev_d = lrc_s;
      unique case (state_q)
        ST_IDLE: begin
          if (lr_chg && !lrc_s) begin
            state_d   = ST_DELAY;
            cnt_d     = FIRST_CNT;
            left_ok_d = 1'b0;
          end
        end
        ST_DELAY, ST_SHIFT: begin
          if (lr_chg) begin
            err_ev    = 1'b1;
            left_ok_d = 1'b0;
            state_d   = ST_DELAY;
            cnt_d     = FIRST_CNT;
          end else begin
            shift_d = word;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_SHIFT;
            if (cnt_q == LAST_CNT) begin
              state_d = ST_WAIT;
              if (!lrc_s) begin
                left_hold_d = word;
                left_ok_d   = 1'b1;
              end else begin
                pair_done = left_ok_q;
                left_ok_d = 1'b0;
              end
            end
          end
        end
        ST_WAIT: begin
          if (lr_chg) begin
            state_d = ST_DELAY;
            cnt_d   = FIRST_CNT;
            if (!lrc_s) left_ok_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_left_d  = data_left_q;
    data_right_d = data_right_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q & ~clr_flags;
    frame_err_d  = (frame_err_q & ~clr_flags) | err_ev;

    // a pair completing on the acceptance cycle replaces the presented one
    if (pair_done) begin
      if (!out_valid_q || out_ready) begin
        data_left_d  = left_hold_q;
        data_right_d = word;
        out_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lrc_prev_q   <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ok_q    <= 1'b0;
      data_left_q  <= '0;
      data_right_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrc_prev_q   <= lrc_prev_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_ok_q    <= left_ok_d;
      data_left_q  <= data_left_d;
      data_right_q <= data_right_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_left  = data_left_q;
  assign data_right = data_right_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx driven by an I2S codec model.
module tb_audio_adc_rx;

  localparam int unsigned W = 24;

  logic sys_clk = 1'b0, reset = 1'b0, bclk = 1'b0, adclrc = 1'b1, adcdat = 1'b0;
  logic out_ready = 1'b0, clr_flags = 1'b0;
  logic signed [W-1:0] data_left, data_right;
  logic out_valid, overrun, frame_err;

  int total = 0, bad = 0, n_acc = 0, exp_n = 0, bhalf = 8;
  bit exp_ferr = 1'b0;
  logic [2*W-1:0] exp_q [$];
  logic signed [W-1:0] last_l = '0, last_r = '0;

  always #10 sys_clk = ~sys_clk;

  audio_adc_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat),
    .data_left(data_left), .data_right(data_right), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .frame_err(frame_err), .clr_flags(clr_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted pair must be the oldest expected one.
  always @(negedge sys_clk) begin
    if (reset && out_valid && out_ready) begin
      check("pair_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("pair_data", 64'({data_left, data_right}), 64'(exp_q.pop_front()));
      last_l = data_left;
      last_r = data_right;
      n_acc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_flags();
    @(posedge sys_clk); #1 clr_flags = 1'b1;
    @(posedge sys_clk); #1 clr_flags = 1'b0;
  endtask

  // One bclk period: data/LR change on the falling edge, sampled by the codec receiver on the rise.
  task automatic slot(input logic lr, input logic d, input int mode);
    repeat (bhalf) @(posedge sys_clk);
    #1 bclk = 1'b0; adclrc = lr; adcdat = d;
    repeat (bhalf) @(posedge sys_clk);
    #1 bclk = 1'b1;
    if (mode == 1) begin
      @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
      check("valid_not_early", 64'(out_valid), 64'd0);
      @(posedge sys_clk); @(negedge sys_clk);
      check("valid_rise_latency", 64'(out_valid), 64'd1);
    end else if (mode == 2) begin
      @(posedge sys_clk); @(posedge sys_clk); #1 out_ready = 1'b1;
      @(posedge sys_clk); #1 out_ready = 1'b0;
      @(negedge sys_clk);
      check("valid_continuous", 64'(out_valid), 64'd1);
    end
  endtask

  // Channel of 32 slots: delay slot, nbits data bits MSB first, random padding.
  task automatic send_chan(input logic lr, input logic [W-1:0] word, input int nbits, input int lsb_mode);
    int slots;
    slots = (nbits == int'(W)) ? 32 : nbits + 1;
    for (int i = 0; i < slots; i++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      if (i >= 1 && i <= nbits) d = word[W - i];
      slot(lr, d, (i == nbits) ? lsb_mode : 0);
    end
  endtask

  // Model: a full left word followed by a full right word yields one pair; a short left word flags an error.
  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lbits,
                            input bit expect_pair, input int rmode);
    if (lbits < int'(W)) exp_ferr = 1'b1;
    else if (expect_pair) begin
      exp_q.push_back({l, r});
      exp_n++;
    end
    send_chan(1'b0, l, lbits, 0);
    send_chan(1'b1, r, W, rmode);
  endtask

  initial begin
    logic [W-1:0] l, r, a_l, a_r, e_l, e_r;
    int lb;

    idle(3);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_left", 64'(data_left), 64'd0);
    check("reset_right", 64'(data_right), 64'd0);

    reset = 1'b1;
    out_ready = 1'b1;
    send_chan(1'b1, '0, W, 0);
    for (int f = 0; f < 3; f++) send_frame(24'h123456, 24'hABCDEF, W, 1'b1, 0);
    idle(4);
    check("basic_pair_count", 64'(n_acc), 64'(exp_n));
    check("basic_valid_low", 64'(out_valid), 64'd0);
    check("basic_frame_err", 64'(frame_err), 64'd0);

    for (int f = 0; f < 8; f++) begin
      bhalf = $urandom_range(4, 10);
      l = W'($urandom);
      r = W'($urandom);
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : int'(W);
      send_frame(l, r, lb, 1'b1, 0);
    end
    bhalf = 8;
    idle(4);
    check("rand_pair_count", 64'(n_acc), 64'(exp_n));
    check("rand_frame_err", 64'(frame_err), 64'(exp_ferr));
    check("rand_queue_drained", 64'(exp_q.size()), 64'd0);
    clear_flags();
    exp_ferr = 1'b0;
    check("clr_frame_err", 64'(frame_err), 64'd0);

    send_frame(24'h5A5A5A, 24'h0F0F0F, 20, 1'b1, 0);
    check("trunc_frame_err", 64'(frame_err), 64'd1);
    send_frame(24'h13579B, 24'h2468AC, W, 1'b1, 0);
    idle(4);
    check("trunc_pair_count", 64'(n_acc), 64'(exp_n));

    send_chan(1'b0, 24'hC0FFEE, W, 0);
    for (int i = 0; i < 12; i++) slot(1'b1, 1'($urandom_range(0, 1)), 0);
    @(posedge sys_clk); #1 reset = 1'b0;
    idle(4);
    check("midreset_frame_err", 64'(frame_err), 64'd0);
    check("midreset_valid", 64'(out_valid), 64'd0);
    #1 reset = 1'b1;
    for (int i = 12; i < 32; i++) slot(1'b1, 1'($urandom_range(0, 1)), 0);
    send_frame(24'h0BEEF1, 24'h7E57ED, W, 1'b1, 0);
    idle(4);
    check("midreset_pair_count", 64'(n_acc), 64'(exp_n));
    check("midreset_no_err", 64'(frame_err), 64'd0);

    send_frame(24'h800000, 24'h7FFFFF, W, 1'b1, 0);
    idle(4);
    check("signed_left", 64'(int'(last_l)), 64'(-8388608));
    check("signed_right", 64'(int'(last_r)), 64'(8388607));

    out_ready = 1'b0;
    a_l = W'($urandom);
    a_r = W'($urandom);
    send_frame(a_l, a_r, W, 1'b1, 1);
    check("hold1_data", 64'({data_left, data_right}), 64'({a_l, a_r}));
    check("hold1_overrun", 64'(overrun), 64'd0);
    send_frame(W'($urandom), W'($urandom), W, 1'b0, 0);
    check("hold2_data", 64'({data_left, data_right}), 64'({a_l, a_r}));
    check("hold2_overrun", 64'(overrun), 64'd1);
    send_frame(W'($urandom), W'($urandom), W, 1'b0, 0);
    check("hold3_data", 64'({data_left, data_right}), 64'({a_l, a_r}));
    check("hold3_valid", 64'(out_valid), 64'd1);
    @(posedge sys_clk); #1 out_ready = 1'b1;
    @(posedge sys_clk); #1 out_ready = 1'b0;
    @(negedge sys_clk);
    check("hold_released_valid", 64'(out_valid), 64'd0);
    clear_flags();
    check("clr_overrun", 64'(overrun), 64'd0);

    send_frame(W'($urandom), W'($urandom), W, 1'b1, 0);
    e_l = W'($urandom);
    e_r = W'($urandom);
    send_frame(e_l, e_r, W, 1'b1, 2);
    check("sameclk_data", 64'({data_left, data_right}), 64'({e_l, e_r}));
    check("sameclk_overrun", 64'(overrun), 64'd0);
    idle(200);
    check("bclk_idle_valid", 64'(out_valid), 64'd1);
    check("bclk_idle_data", 64'({data_left, data_right}), 64'({e_l, e_r}));
    out_ready = 1'b1;
    idle(4);
    check("final_pair_count", 64'(n_acc), 64'(exp_n));
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
